// File: rtl/program_loader_pkg.sv
// Shared constants for the program loader: FSM encodings and stream sizes.
// Optional trailer checksum is enabled with LOADER_CHECKSUM_EN.
package program_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_HI = 3'd1,
        S_HDR_LO = 3'd2,
        S_DATA   = 3'd3,
        S_FINISH = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam int HDR_BYTES = 2;
    localparam int BYTE_W    = 8;
    localparam int WORD_W    = 32;

endpackage

// File: rtl/program_loader_if.sv
// Byte stream, program-memory write port and status of the program loader.
// master = host/byte source side, slave = loader side.
interface program_loader_if;

    logic        start;
    logic [0:7]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [0:31] pm_wadr;
    logic [0:31] pm_wvalue;
    logic        pm_wenable;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [0:15] words_loaded;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, pm_wadr, pm_wvalue, pm_wenable,
        input  cpu_hold, done, error, words_loaded
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, pm_wadr, pm_wvalue, pm_wenable,
        output cpu_hold, done, error, words_loaded
    );

endinterface

// File: rtl/program_loader_byte_packer.sv
// Packs four MSB-first bytes into a big-endian word.
// word/word_ready are presented in the cycle the 4th byte is accepted.
module program_loader_byte_packer
    import program_loader_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            clear,
    input  logic [0:BYTE_W-1] byte_in,
    input  logic            valid,
    output logic [0:WORD_W-1] word,
    output logic            word_ready
);

    logic [0:23] sr;
    logic [1:0]  cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clear) begin
            sr  <= '0;
            cnt <= '0;
        end else if (valid) begin
            sr  <= {sr[8:23], byte_in};
            cnt <= cnt + 2'd1;
        end
    end

    assign word       = {sr, byte_in};
    assign word_ready = valid & (cnt == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Program loader: header-counted byte stream to program-memory word writes.
// LOADER_CHECKSUM_EN adds an XOR trailer byte checked in FINISH.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
)
(
    input  logic clock,
    input  logic reset_n,
    program_loader_if.slave bus
);

    localparam logic [32:0] LIMIT = 33'(1) << ADDR_WIDTH;
    localparam logic [31:0] BASE  = 32'(BASE_ADDR);

    state_t      state;
    state_t      nxt;
    logic        rdy;
    logic        hs;
    logic        start_ok;
    logic        ovf;
    logic        word_ready;
    logic        last_word;
    logic [31:0] word;
    logic [7:0]  n_hi;
    logic [15:0] n_hdr;
    logic [15:0] n_left;
    logic [15:0] wcnt;
    logic [31:0] wadr;
    logic [31:0] wval;
    logic        wen;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign start_ok = bus.start & ((state == S_IDLE) |
                                   (state == S_DONE) |
                                   (state == S_ERR));
    assign hs    = bus.byte_valid & rdy;
    assign n_hdr = {n_hi, bus.byte_in};
    // Compare in 33 bits so N up to 65535 cannot wrap.
    assign ovf   = (33'(BASE) + 33'(n_hdr)) > LIMIT;
    assign last_word = word_ready & (n_left == 16'd1);

    program_loader_byte_packer u_packer (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (start_ok),
        .byte_in    (bus.byte_in),
        .valid      (hs & (state == S_DATA)),
        .word       (word),
        .word_ready (word_ready)
    );

    always_comb begin
        rdy = 1'b0;
        unique case (state)
            S_HDR_HI, S_HDR_LO, S_DATA: rdy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_FINISH: rdy = 1'b1;
`endif
            default: rdy = 1'b0;
        endcase
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_ok) nxt = S_HDR_HI;
            end
            S_HDR_HI: begin
                if (hs) nxt = S_HDR_LO;
            end
            S_HDR_LO: begin
                if (hs) begin
                    if (ovf)
                        nxt = S_ERR;
                    else if (n_hdr == 16'd0)
                        nxt = S_FINISH;
                    else
                        nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (last_word) nxt = S_FINISH;
            end
            S_FINISH: begin
`ifdef LOADER_CHECKSUM_EN
                if (hs)
                    nxt = (bus.byte_in == csum) ? S_DONE : S_ERR;
`else
                nxt = S_DONE;
`endif
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            n_hi   <= '0;
            n_left <= '0;
            wcnt   <= '0;
            wadr   <= BASE;
            wval   <= '0;
            wen    <= 1'b0;
        end else begin
            wen <= word_ready;
            if (start_ok)
                wcnt <= '0;
            if (hs && state == S_HDR_HI)
                n_hi <= bus.byte_in;
            if (hs && state == S_HDR_LO)
                n_left <= n_hdr;
            if (word_ready) begin
                wadr   <= BASE + {16'd0, wcnt};
                wval   <= word;
                wcnt   <= wcnt + 16'd1;
                n_left <= n_left - 16'd1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            csum <= '0;
        else if (start_ok)
            csum <= '0;
        else if (hs && state != S_FINISH)
            csum <= csum ^ bus.byte_in;
    end
`endif

    assign bus.byte_ready   = rdy;
    assign bus.pm_wadr      = wadr;
    assign bus.pm_wvalue    = wval;
    assign bus.pm_wenable   = wen;
    assign bus.words_loaded = wcnt;
    assign bus.done         = (state == S_DONE);
    assign bus.error        = (state == S_ERR);
    // Hold drops only in DONE and re-asserts as soon as a new start is seen.
    assign bus.cpu_hold     = (state != S_DONE) | start_ok;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader with randomized byte streams.
// Build with LOADER_CHECKSUM_EN to also exercise the trailer checksum.
module tb_program_loader;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    program_loader_if bus ();

    program_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] val;
    } wr_t;

    int          checks = 0;
    int          failures = 0;
    wr_t         expq[$];
    wr_t         got;
    logic [7:0]  data_q[$];
    logic [31:0] model_mem[256];
    logic [31:0] dut_mem[256];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.pm_wenable === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write adr=%h val=%h",
                         bus.pm_wadr, bus.pm_wvalue);
            end else begin
                got = expq.pop_front();
                chk("wadr", bus.pm_wadr, got.adr);
                chk("wvalue", bus.pm_wvalue, got.val);
            end
            dut_mem[bus.pm_wadr[24:31]] = bus.pm_wvalue;
        end
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        @(negedge clk);
        while (!bus.byte_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!bus.byte_ready) begin
            checks++;
            failures++;
            $display("FAIL byte_ready_timeout byte=%h", b);
        end
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
        bus.byte_in    = '0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
    endtask

    function automatic int pick_gap(input int maxgap);
        return (maxgap == 0) ? 0 : int'($urandom_range(1, maxgap));
    endfunction

    task automatic fill(input int n);
        data_q.delete();
        for (int i = 0; i < 4 * n; i++)
            data_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // One session: header n, data from data_q, optional trailer.
    task automatic run(input int n, input int maxgap,
                       input bit poke, input bit bad);
        logic [15:0] nn;
        logic [7:0]  cs;
        logic [31:0] w;
        bit          ovf;
        bit          was_end;
        int          k;
        nn  = 16'(n);
        ovf = (n > 256);
        if (!ovf) begin
            for (int i = 0; i < n; i++) begin
                w = {data_q[4*i], data_q[4*i+1],
                     data_q[4*i+2], data_q[4*i+3]};
                expq.push_back('{adr: 32'(i), val: w});
                model_mem[i] = w;
            end
        end
        was_end = bus.done | bus.error;
        bus.start = 1'b1;
        #1;
        chk("hold_on_start", {31'd0, bus.cpu_hold}, 32'd1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        if (was_end) begin
            chk("clr_done", {31'd0, bus.done}, 32'd0);
            chk("clr_error", {31'd0, bus.error}, 32'd0);
            chk("clr_words", 32'(bus.words_loaded), 32'd0);
        end
        cs = nn[15:8] ^ nn[7:0];
        send(nn[15:8], pick_gap(maxgap));
        send(nn[7:0], 0);
        k = 0;
        if (n == 0) begin
            @(negedge clk);
            while (!bus.done && k < 10) begin
                k++;
                @(negedge clk);
            end
            chk("n0_latency_ok", 32'(k <= 3), 32'd1);
        end
        if (!ovf) begin
            for (int i = 0; i < 4 * n; i++) begin
                send(data_q[i], pick_gap(maxgap));
                cs ^= data_q[i];
                if (poke && i == 1) pulse_start();
            end
`ifdef LOADER_CHECKSUM_EN
            send(cs ^ {7'd0, bad}, 0);
`endif
        end
        k = 0;
        @(negedge clk);
        while (!(bus.done || bus.error) && k < 30) begin
            k++;
            @(negedge clk);
        end
        chk("end_in_time", 32'(k < 30), 32'd1);
        if (ovf) begin
            chk("ovf_error", {31'd0, bus.error}, 32'd1);
            chk("ovf_done", {31'd0, bus.done}, 32'd0);
            chk("ovf_hold", {31'd0, bus.cpu_hold}, 32'd1);
            chk("ovf_words", 32'(bus.words_loaded), 32'd0);
        end else if (bad) begin
            chk("cs_error", {31'd0, bus.error}, 32'd1);
            chk("cs_done", {31'd0, bus.done}, 32'd0);
            chk("cs_hold", {31'd0, bus.cpu_hold}, 32'd1);
            chk("cs_words", 32'(bus.words_loaded), 32'(n));
        end else begin
            chk("done", {31'd0, bus.done}, 32'd1);
            chk("error", {31'd0, bus.error}, 32'd0);
            chk("hold", {31'd0, bus.cpu_hold}, 32'd0);
            chk("words", 32'(bus.words_loaded), 32'(n));
        end
        chk("pending_writes", 32'(expq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_ready"}, {31'd0, bus.byte_ready}, 32'd0);
        chk({tag, "_wen"}, {31'd0, bus.pm_wenable}, 32'd0);
        chk({tag, "_wadr"}, bus.pm_wadr, 32'd0);
        chk({tag, "_wval"}, bus.pm_wvalue, 32'd0);
        chk({tag, "_hold"}, {31'd0, bus.cpu_hold}, 32'd1);
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_error"}, {31'd0, bus.error}, 32'd0);
        chk({tag, "_words"}, 32'(bus.words_loaded), 32'd0);
    endtask

    initial begin
        int bad_img;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = '0;
            dut_mem[i]   = '0;
        end
        bus.start      = 1'b0;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        reset_vals("rst");
        #20;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        data_q = '{8'h20, 8'h01, 8'h00, 8'h05,
                   8'h00, 8'h22, 8'h18, 8'h20};
        run(2, 0, 0, 0);
        chk("img0", dut_mem[0], 32'h20010005);
        chk("img1", dut_mem[1], 32'h00221820);

        data_q.delete();
        run(0, 0, 0, 0);
        run(257, 0, 0, 0);

        pulse_start();
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'hAA, 0);
        send(8'hBB, 0);
        rst_n = 1'b0;
        #1;
        reset_vals("midrst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        data_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        run(1, 0, 0, 0);
        chk("img_after_rst", dut_mem[0], 32'h12345678);

        fill(3);
        run(3, 5, 1, 0);

        for (int s = 0; s < 6; s++) begin
            fill(int'($urandom_range(1, 8)));
            run(data_q.size() / 4, int'($urandom_range(0, 5)), 0, 0);
        end

        fill(5);
        run(5, 0, 0, 0);
        run(5, 5, 0, 0);

`ifdef LOADER_CHECKSUM_EN
        data_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run(1, 0, 0, 0);
        run(1, 0, 0, 1);
`endif

        bad_img = 0;
        for (int i = 0; i < 256; i++)
            if (dut_mem[i] !== model_mem[i]) bad_img++;
        chk("mem_image_diffs", 32'(bad_img), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
